// File: rtl/serdes_pkg.sv
// serdes_pkg: shared K28.5 comma codes, default symbol width and receive alignment states
package serdes_pkg;
  localparam int WIDTH_DEF = 10;
  localparam logic [9:0] K28P5_RDN = 10'h17C;
  localparam logic [9:0] K28P5_RDP = 10'h283;
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/comma_detect.sv
// comma_detect: combinational match of a WIDTH-bit window against either comma disparity
module comma_detect
  import serdes_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COMMA_P = K28P5_RDN,
  parameter logic [WIDTH-1:0] COMMA_N = K28P5_RDP
) (
  input  logic [WIDTH-1:0] win,
  output logic             match
);
  assign match = (win == COMMA_P) || (win == COMMA_N);
endmodule

// File: rtl/ser_par_align.sv
// ser_par_align: serial-to-parallel receiver with comma word alignment; ERR_CNT_EN adds err_cnt
module ser_par_align
  import serdes_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COMMA_P = K28P5_RDN,
  parameter logic [WIDTH-1:0] COMMA_N = K28P5_RDP,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             data_in,
  input  logic             enable,
  input  logic             rxpol,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             locked,
  output logic             comma_det,
  output logic             align_err
`ifdef ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  logic [WIDTH-1:0] sr, win;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good;
  logic [BW-1:0] bad;
  state_t state;
  logic match, boundary, off, lost, hunt_hit, realign, lock_now;
  assign win = {data_in ^ rxpol, sr[WIDTH-1:1]};
  assign boundary = cnt == CW'(WIDTH - 1);
  assign off = match && !boundary && state != HUNT;
  assign lost = off && state == LOCKED && 32'(bad) + 32'd1 == LOSS_COUNT;
  // losing lock on a comma treats that comma as a fresh hunt hit
  assign hunt_hit = (match && state == HUNT) || lost;
  assign realign = hunt_hit || (off && state == CHECK);
  assign lock_now = hunt_hit ? LOCK_COUNT == 1
                  : state == CHECK && match && boundary && 32'(good) + 32'd1 == LOCK_COUNT;
  comma_detect #(.WIDTH(WIDTH), .COMMA_P(COMMA_P), .COMMA_N(COMMA_N)) u_det (
    .win  (win),
    .match(match)
  );
  always_ff @(posedge reloj) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      good      <= '0;
      bad       <= '0;
      state     <= HUNT;
      data_out  <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      comma_det <= 1'b0;
      align_err <= 1'b0;
`ifdef ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      valid     <= 1'b0;
      comma_det <= 1'b0;
      align_err <= 1'b0;
      if (enable) begin
        sr        <= win;
        cnt       <= (boundary || realign) ? '0 : cnt + 1'b1;
        comma_det <= match;
        align_err <= off;
        if (realign) good <= GW'(1);
        else if (state == CHECK && match && boundary) good <= good + 1'b1;
        if (lock_now) begin
          state  <= LOCKED;
          locked <= 1'b1;
          bad    <= '0;
        end else if (realign) begin
          state  <= CHECK;
          locked <= 1'b0;
          bad    <= '0;
        end else if (state == LOCKED && off) bad <= bad + 1'b1;
        else if (state == LOCKED && match && boundary) bad <= '0;
        if (lock_now || (state == LOCKED && boundary)) begin
          data_out <= win;
          valid    <= 1'b1;
        end
`ifdef ERR_CNT_EN
        if (off && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ser_par_align.sv
// tb_ser_par_align: directed bench for lock, polarity, loss, enable hold, reset and ERR_CNT_EN counter
module tb_ser_par_align;
  logic reloj = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic enable = 1'b0;
  logic rxpol = 1'b0;
  logic [9:0] data_out;
  logic valid, locked, comma_det, align_err;
`ifdef ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  logic [9:0] kp = 10'h17C;
  logic [9:0] kn = 10'h283;
  logic [9:0] dw = 10'h155;
  int n_chk = 0;
  int n_bad = 0;
  always #5 reloj = ~reloj;
  ser_par_align dut (
    .reloj    (reloj),
    .reset    (reset),
    .data_in  (data_in),
    .enable   (enable),
    .rxpol    (rxpol),
    .data_out (data_out),
    .valid    (valid),
    .locked   (locked),
    .comma_det(comma_det),
    .align_err(align_err)
`ifdef ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge reloj);
    reset = 1'b0;
    enable = 1'b1;
    data_in = b ^ rxpol;
    @(posedge reloj);
    #1;
  endtask
  task automatic send_bits(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask
  task automatic hold();
    @(negedge reloj);
    enable = 1'b0;
    data_in = ~data_in;
    @(posedge reloj);
    #1;
  endtask
  task automatic do_reset();
    @(negedge reloj);
    reset = 1'b1;
    enable = 1'b1;
    data_in = 1'b1;
    @(posedge reloj);
    #1;
  endtask
  task automatic check_idle(input string p);
    check({p, "_data"}, 32'(data_out), 0);
    check({p, "_valid"}, 32'(valid), 0);
    check({p, "_locked"}, 32'(locked), 0);
    check({p, "_comma"}, 32'(comma_det), 0);
    check({p, "_aerr"}, 32'(align_err), 0);
  endtask
  task automatic lock_seq(input string p);
    send_bits(10'h005, 3);
    send_bits(kp, 9);
    check({p, "_e12_comma"}, 32'(comma_det), 0);
    send_bit(kp[9]);
    check({p, "_e13_comma"}, 32'(comma_det), 1);
    check({p, "_e13_locked"}, 32'(locked), 0);
    check({p, "_e13_valid"}, 32'(valid), 0);
    send_bits(kn, 10);
    check({p, "_e23_comma"}, 32'(comma_det), 1);
    check({p, "_e23_locked"}, 32'(locked), 0);
    check({p, "_e23_valid"}, 32'(valid), 0);
    send_bits(kp, 10);
    check({p, "_e33_comma"}, 32'(comma_det), 1);
    check({p, "_e33_locked"}, 32'(locked), 1);
    check({p, "_e33_valid"}, 32'(valid), 1);
    check({p, "_e33_data"}, 32'(data_out), 32'h17C);
    send_bit(dw[0]);
    check({p, "_e34_valid"}, 32'(valid), 0);
    check({p, "_e34_locked"}, 32'(locked), 1);
    send_bits(dw >> 1, 9);
    check({p, "_e43_valid"}, 32'(valid), 1);
    check({p, "_e43_data"}, 32'(data_out), 32'h155);
    check({p, "_e43_comma"}, 32'(comma_det), 0);
  endtask
  initial begin
    logic seen_v, seen_c;
    do_reset();
    check_idle("rst");
    lock_seq("lock");
    send_bits(dw, 5);
    for (int i = 0; i < 5; i++) begin
      hold();
      check($sformatf("hold%0d_valid", i), 32'(valid), 0);
      check($sformatf("hold%0d_comma", i), 32'(comma_det), 0);
    end
    check("hold_locked", 32'(locked), 1);
    check("hold_data", 32'(data_out), 32'h155);
    send_bits(dw >> 5, 4);
    check("en_early_valid", 32'(valid), 0);
    send_bit(dw[9]);
    check("en_late_valid", 32'(valid), 1);
    check("en_late_data", 32'(data_out), 32'h155);
    for (int k = 0; k < 4; k++) begin
      send_bit(k[0]);
      send_bits(k[0] ? kn : kp, 10);
      check($sformatf("slip%0d_aerr", k), 32'(align_err), 1);
      check($sformatf("slip%0d_locked", k), 32'(locked), k < 3 ? 1 : 0);
    end
    send_bits(kp, 10);
    check("relock1_locked", 32'(locked), 0);
    check("relock1_aerr", 32'(align_err), 0);
    check("relock1_comma", 32'(comma_det), 1);
    check("relock1_valid", 32'(valid), 0);
    send_bits(kn, 10);
    check("relock2_locked", 32'(locked), 1);
    check("relock2_valid", 32'(valid), 1);
    check("relock2_data", 32'(data_out), 32'h283);
    send_bits(dw, 4);
    do_reset();
    check_idle("midrst");
    seen_v = 1'b0;
    seen_c = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 10; j++) begin
        send_bit(dw[j]);
        seen_v |= valid;
        seen_c |= comma_det;
      end
    check("postrst_valid", 32'(seen_v), 0);
    check("postrst_comma", 32'(seen_c), 0);
    check("postrst_locked", 32'(locked), 0);
    @(negedge reloj);
    rxpol = 1'b1;
    do_reset();
    check_idle("pol_rst");
    lock_seq("pol");
`ifdef ERR_CNT_EN
    @(negedge reloj);
    rxpol = 1'b0;
    do_reset();
    check("ec_rst", 32'(err_cnt), 0);
    send_bits(kp, 10);
    check("ec_hunt", 32'(err_cnt), 0);
    for (int i = 0; i < 305; i++) begin
      send_bit(i[0] ? 1'b0 : 1'b1);
      send_bits(i[0] ? kp : kn, 10);
      if (i == 0) check("ec_first", 32'(err_cnt), 1);
      if (i == 299) check("ec_sat", 32'(err_cnt), 32'hFF);
    end
    check("ec_hold", 32'(err_cnt), 32'hFF);
    check("ec_aerr", 32'(align_err), 1);
    do_reset();
    check("ec_clear", 32'(err_cnt), 0);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
